// File: rtl/cla_seq_adder_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead add/subtract controller.
//   state_e : controller FSM states (idle, running nibbles, result held)
//   NIB_W   : width of one slice nibble in bits
//   OP_ADD / OP_SUB : encoding of the op_sub request input
package cla_seq_adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned NIB_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cla_seq_adder_slice.sv
// Purely combinational 4-bit carry-lookahead slice.
//   x, y : nibble operands
//   ci   : carry into bit 0
//   s    : nibble sum
//   co   : carry out of bit 3
//   c3   : carry into bit 3 (used for signed overflow on the top nibble)
module cla4_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;

    assign g = x & y;
    assign p = x ^ y;

    // Every carry is a flat sum of products of generate/propagate terms.
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_seq_adder.sv
// Nibble-serial add/subtract controller sharing one 4-bit CLA slice across WIDTH bits.
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   in_valid, in_ready  : request handshake (in_ready is combinational)
//   a, b, cin, op_sub   : operands, carry-in (ignored on subtract), 0 = add / 1 = subtract
//   out_valid, out_ready: result handshake
//   sum, cout, ovf      : registered result, carry out of the MSB, signed overflow
// WIDTH must be a multiple of 4 and at least 8; an operation takes WIDTH/4 RUN cycles.
module cla_seq_adder
    import cla_seq_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_e             state;
    logic [IDX_W-1:0]   nib_idx;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;

    int unsigned        base;
    logic [NIB_W-1:0]   slice_x;
    logic [NIB_W-1:0]   slice_y;
    logic [NIB_W-1:0]   slice_s;
    logic               slice_co;
    logic               slice_c3;

    assign in_ready = (state == StIdle) && !rst;

    // Bit offset of the nibble currently on the slice.
    always_comb begin
        base = 32'(nib_idx) * NIB_W;
    end

    assign slice_x = a_q[base +: NIB_W];
    assign slice_y = b_q[base +: NIB_W];

    cla4_slice u_slice (
        .x  (slice_x),
        .y  (slice_y),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co),
        .c3 (slice_c3)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            nib_idx   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        a_q <= a;
                        // Subtract is a + ~b + 1, so the +1 rides in on the initial carry.
                        if (op_sub == OP_SUB) begin
                            b_q     <= ~b;
                            carry_q <= 1'b1;
                        end else begin
                            b_q     <= b;
                            carry_q <= cin;
                        end
                        nib_idx <= '0;
                        state   <= StRun;
                    end
                end
                StRun: begin
                    sum[base +: NIB_W] <= slice_s;
                    carry_q            <= slice_co;
                    // Only the top nibble's value survives, which is the one that matters.
                    ovf                <= slice_c3 ^ slice_co;
                    if (nib_idx == IDX_W'(NIB - 1)) begin
                        cout      <= slice_co;
                        out_valid <= 1'b1;
                        state     <= StDone;
                    end else begin
                        nib_idx <= nib_idx + IDX_W'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
